// File: rtl/uart_echo_buffer.sv
// UART echo path: edge-detects RX words, buffers them in a FIFO with an
// optional run-time transform, and drives the TX load handshake from a 3-state FSM.
module uart_echo_buffer #(
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int ACK_TIMEOUT = 4096,
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clockIN,
  input  logic                  resetIN,
  input  logic [1:0]            modeIN,
  input  logic                  clearIN,
  input  logic                  rxReadyIN,
  input  logic [DATA_WIDTH-1:0] rxDataIN,
  input  logic                  txReadyIN,
  output logic                  txLoadOUT,
  output logic [DATA_WIDTH-1:0] txDataOUT,
  output logic [CW-1:0]         fifoCountOUT,
  output logic                  fifoEmptyOUT,
  output logic                  fifoFullOUT,
  output logic                  overflowOUT,
  output logic                  txErrorOUT
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(ACK_TIMEOUT);

  typedef enum logic [1:0] {
    MODE_ECHO    = 2'b00,
    MODE_INVERT  = 2'b01,
    MODE_HOLD    = 2'b10,
    MODE_DISCARD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT
  } state_e;

  mode_e                  mode;
  state_e                 state_q, state_d;
  logic                   rx_sync_q, rx_sync_d;
  logic                   rx_prev_q, rx_prev_d;
  logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic                   tx_error_q, tx_error_d;
  logic                   tx_load_q, tx_load_d;
  logic [DATA_WIDTH-1:0]  tx_data_q, tx_data_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];

  logic                   empty, full, push_req, push_ok, pop, timeout_hit, mem_we;
  logic [DATA_WIDTH-1:0]  wr_data;

  assign mode    = mode_e'(modeIN);
  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign wr_data = (mode == MODE_INVERT) ? ~rx_data_q : rx_data_q;

  // TX handshake FSM: pop happens in IDLE, so the word is registered into
  // txDataOUT on the same edge that raises txLoadOUT.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
    state_d     = state_q;
    tx_load_d   = tx_load_q;
    tx_data_d   = tx_data_q;
    tmo_d       = tmo_q;
    pop         = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty && txReadyIN && mode != MODE_HOLD) begin
          pop       = 1'b1;
          tx_data_d = mem_q[rd_ptr_q];
          tx_load_d = 1'b1;
          tmo_d     = '0;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (!txReadyIN) begin
          tx_load_d = 1'b0;
          state_d   = ST_WAIT;
        end else if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
          tx_load_d   = 1'b0;
          timeout_hit = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_WAIT: begin
        if (txReadyIN) state_d = ST_IDLE;
      end
      default: begin
        tx_load_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // RX edge detection and FIFO bookkeeping; clearIN overrides any push.
  always_comb begin
    rx_sync_d  = rxReadyIN;
    rx_prev_d  = rx_sync_q;
    rx_data_d  = rxDataIN;
    push_req   = rx_sync_q && !rx_prev_q && (mode != MODE_DISCARD);
    push_ok    = push_req && (!full || pop);
    mem_we     = push_ok && !clearIN;
    wr_ptr_d   = wr_ptr_q + PW'(push_ok);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    overflow_d = overflow_q || (push_req && !push_ok);
    tx_error_d = tx_error_q || timeout_hit;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (clearIN) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      tx_error_d = 1'b0;
    end
  end

  always_ff @(posedge clockIN or posedge resetIN) begin
    if (resetIN) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q    <= ST_IDLE;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_data_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      tx_error_q <= 1'b0;
      tx_load_q  <= 1'b0;
      tx_data_q  <= '0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      rx_sync_q  <= rx_sync_d;
      rx_prev_q  <= rx_prev_d;
      rx_data_q  <= rx_data_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      tx_error_q <= tx_error_d;
      tx_load_q  <= tx_load_d;
      tx_data_q  <= tx_data_d;
      tmo_q      <= tmo_d;
    end
  end

  // NOTE: storage has no reset; occupancy and pointers alone decide which entries are valid.
  always_ff @(posedge clockIN) begin
    if (mem_we) mem_q[wr_ptr_q] <= wr_data;
  end

  assign txLoadOUT    = tx_load_q;
  assign txDataOUT    = tx_data_q;
  assign fifoCountOUT = count_q;
  assign fifoEmptyOUT = empty;
  assign fifoFullOUT  = full;
  assign overflowOUT  = overflow_q;
  assign txErrorOUT   = tx_error_q;

endmodule
